// File: rtl/jtcontra_rom_arb.sv
// rtl/jtcontra_rom_arb.sv - two-port cached ROM read arbiter over one SDRAM read channel
//
// Purpose: shares a single SDRAM read channel between the main CPU ROM port and
// the sound CPU ROM port. Each port keeps a one-word (16-bit) cache so hits
// return data combinationally and only misses generate SDRAM traffic.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   main_cs/main_addr                main CPU ROM request (level) and byte address
//   main_data/main_ok                main read byte and hit flag
//   snd_cs/snd_addr                  sound CPU ROM request (level) and byte address
//   snd_data/snd_ok                  sound read byte and hit flag
//   sdram_req/sdram_addr             SDRAM read request (held until ack) and word address
//   sdram_ack/sdram_dst/sdram_din    SDRAM accept, data strobe and read word

module jtcontra_rom_arb #(
   parameter int                  MAIN_AW    = 18,
   parameter int                  SND_AW     = 15,
   parameter int                  SDRAM_AW   = 22,
   parameter logic [SDRAM_AW-1:0] SND_OFFSET = 22'h1_0000
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                main_cs,
   input  logic [MAIN_AW-1:0]  main_addr,
   output logic [7:0]          main_data,
   output logic                main_ok,
   input  logic                snd_cs,
   input  logic [SND_AW-1:0]   snd_addr,
   output logic [7:0]          snd_data,
   output logic                snd_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                sdram_dst,
   input  logic [15:0]         sdram_din
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;   // 0: main, 1: sound
   logic                  last_q, last_d;     // port served most recently
   logic                  req_q, req_d;
   logic [SDRAM_AW-1:0]   addr_q, addr_d;
   logic [MAIN_AW-2:0]    m_ftag_q, m_ftag_d; // tag of the word being fetched
   logic [SND_AW-2:0]     s_ftag_q, s_ftag_d;

   logic                  m_valid_q, m_valid_d;
   logic [MAIN_AW-2:0]    m_tag_q, m_tag_d;
   logic [15:0]           m_cache_q, m_cache_d;
   logic                  s_valid_q, s_valid_d;
   logic [SND_AW-2:0]     s_tag_q, s_tag_d;
   logic [15:0]           s_cache_q, s_cache_d;

   logic                  main_hit, snd_hit, main_miss, snd_miss, fill;
   logic [SDRAM_AW-1:0]   main_word, snd_word;

   assign main_hit  = main_cs & m_valid_q & (m_tag_q == main_addr[MAIN_AW-1:1]);
   assign snd_hit   = snd_cs  & s_valid_q & (s_tag_q == snd_addr[SND_AW-1:1]);
   assign main_miss = main_cs & ~main_hit;
   assign snd_miss  = snd_cs  & ~snd_hit;

   assign main_word = SDRAM_AW'(main_addr[MAIN_AW-1:1]);
   // Addition wraps naturally at SDRAM_AW bits.
   assign snd_word  = SND_OFFSET + SDRAM_AW'(snd_addr[SND_AW-1:1]);

   assign main_ok    = main_hit;
   assign snd_ok     = snd_hit;
   assign main_data  = main_addr[0] ? m_cache_q[15:8] : m_cache_q[7:0];
   assign snd_data   = snd_addr[0]  ? s_cache_q[15:8] : s_cache_q[7:0];
   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      req_d     = req_q;
      addr_d    = addr_q;
      m_ftag_d  = m_ftag_q;
      s_ftag_d  = s_ftag_q;
      m_valid_d = m_valid_q;
      m_tag_d   = m_tag_q;
      m_cache_d = m_cache_q;
      s_valid_d = s_valid_q;
      s_tag_d   = s_tag_q;
      s_cache_d = s_cache_q;
      fill      = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the port that was not served last wins.
            if (main_miss && (!snd_miss || last_q)) begin
               grant_d  = 1'b0;
               m_ftag_d = main_addr[MAIN_AW-1:1];
               addr_d   = main_word;
               req_d    = 1'b1;
               state_d  = REQ;
            end else if (snd_miss) begin
               grant_d  = 1'b1;
               s_ftag_d = snd_addr[SND_AW-1:1];
               addr_d   = snd_word;
               req_d    = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (sdram_ack) begin
               req_d   = 1'b0;
               state_d = WAIT;
               if (sdram_dst) begin
                  fill    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT: begin
            if (sdram_dst) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The fill uses the tag latched at grant time, not the live address,
      // so the port re-evaluates hit/miss against whatever it presents now.
      if (fill) begin
         last_d = grant_q;
         if (!grant_q) begin
            m_valid_d = 1'b1;
            m_tag_d   = m_ftag_q;
            m_cache_d = sdram_din;
         end else begin
            s_valid_d = 1'b1;
            s_tag_d   = s_ftag_q;
            s_cache_d = sdram_din;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         req_q     <= 1'b0;
         addr_q    <= '0;
         m_ftag_q  <= '0;
         s_ftag_q  <= '0;
         m_valid_q <= 1'b0;
         m_tag_q   <= '0;
         m_cache_q <= '0;
         s_valid_q <= 1'b0;
         s_tag_q   <= '0;
         s_cache_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         m_ftag_q  <= m_ftag_d;
         s_ftag_q  <= s_ftag_d;
         m_valid_q <= m_valid_d;
         m_tag_q   <= m_tag_d;
         m_cache_q <= m_cache_d;
         s_valid_q <= s_valid_d;
         s_tag_q   <= s_tag_d;
         s_cache_q <= s_cache_d;
      end
   end

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// tb/tb_jtcontra_rom_arb.sv - self-checking bench for jtcontra_rom_arb

module tb_jtcontra_rom_arb;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        main_cs = 1'b0;
   logic [17:0] main_addr = '0;
   logic [7:0]  main_data;
   logic        main_ok;
   logic        snd_cs = 1'b0;
   logic [14:0] snd_addr = '0;
   logic [7:0]  snd_data;
   logic        snd_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack = 1'b0;
   logic        sdram_dst = 1'b0;
   logic [15:0] sdram_din = '0;

   // second instance: sound offset at the top of SDRAM to exercise wrap-around
   logic        m2_cs = 1'b0;
   logic [17:0] m2_addr = '0;
   logic [7:0]  m2_data;
   logic        m2_ok;
   logic        s2_cs = 1'b0;
   logic [14:0] s2_addr = '0;
   logic [7:0]  s2_data;
   logic        s2_ok;
   logic        req2;
   logic [21:0] addr2;
   logic        ack2 = 1'b0;
   logic        dst2 = 1'b0;
   logic [15:0] din2 = '0;

   int passed = 0;
   int total  = 0;

   logic [21:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];
   logic [21:0] ea;
   logic [7:0]  ed;
   bit          got;
   int          lat;

   always #5 clk = ~clk;

   jtcontra_rom_arb dut (
      .clk(clk), .rstn(rstn),
      .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
      .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .sdram_dst(sdram_dst), .sdram_din(sdram_din)
   );

   jtcontra_rom_arb #(.SND_OFFSET(22'h3FFFFF)) dut2 (
      .clk(clk), .rstn(rstn),
      .main_cs(m2_cs), .main_addr(m2_addr), .main_data(m2_data), .main_ok(m2_ok),
      .snd_cs(s2_cs), .snd_addr(s2_addr), .snd_data(s2_data), .snd_ok(s2_ok),
      .sdram_req(req2), .sdram_addr(addr2), .sdram_ack(ack2),
      .sdram_dst(dst2), .sdram_din(din2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      main_cs = 1'b0; snd_cs = 1'b0; sdram_ack = 1'b0; sdram_dst = 1'b0;
      s2_cs = 1'b0; ack2 = 1'b0; dst2 = 1'b0;
      rstn = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      tick();
   endtask

   // Waits (bounded) for sdram_req; lat counts cycles waited.
   task automatic wait_req(output bit g, output int l);
      g = 1'b0;
      l = 0;
      for (int i = 0; i < 20; i++) begin
         if (sdram_req === 1'b1) begin
            g = 1'b1;
            break;
         end
         tick();
         l++;
      end
   endtask

   // SDRAM responder: ack after ack_dly cycles, dst dst_dly cycles after ack.
   task automatic respond(input int ack_dly, input int dst_dly, input logic [15:0] din);
      repeat (ack_dly) tick();
      sdram_ack = 1'b1;
      if (dst_dly == 0) begin
         sdram_dst = 1'b1;
         sdram_din = din;
      end
      tick();
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      if (dst_dly > 0) begin
         repeat (dst_dly - 1) tick();
         sdram_dst = 1'b1;
         sdram_din = din;
         tick();
         sdram_dst = 1'b0;
      end
   endtask

   task automatic test_reset();
      tick();
      main_cs = 1'b1; main_addr = 18'h00050; snd_cs = 1'b1; snd_addr = 15'h0000;
      #1;
      total++; if (sdram_req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", sdram_req); else passed++;
      total++; if (sdram_addr !== 22'h0) $display("FAIL rst_addr got=%h exp=0", sdram_addr); else passed++;
      total++; if (main_ok !== 1'b0) $display("FAIL rst_main_ok got=%0b exp=0", main_ok); else passed++;
      total++; if (snd_ok !== 1'b0) $display("FAIL rst_snd_ok got=%0b exp=0", snd_ok); else passed++;
      snd_cs = 1'b0;
      rstn = 1'b1;
      wait_req(got, lat);
      total++; if (!got) $display("FAIL rst_req_timeout got=0 exp=1"); else passed++;
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      // now in WAIT; reset asynchronously
      rstn = 1'b0;
      #1;
      total++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0)
         $display("FAIL rst_midwait req=%0b addr=%h exp req=0 addr=0", sdram_req, sdram_addr); else passed++;
      total++; if (main_ok !== 1'b0) $display("FAIL rst_midwait_ok got=%0b exp=0", main_ok); else passed++;
      main_cs = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      sdram_dst = 1'b1; sdram_din = 16'hAAAA;
      tick();
      sdram_dst = 1'b0;
      main_cs = 1'b1; snd_cs = 1'b1; snd_addr = 15'h0000;
      #1;
      total++; if (main_ok !== 1'b0) $display("FAIL rst_stray_dst_main got=%0b exp=0", main_ok); else passed++;
      total++; if (snd_ok !== 1'b0) $display("FAIL rst_stray_dst_snd got=%0b exp=0", snd_ok); else passed++;
      do_reset();
   endtask

   task automatic test_main_miss_hit();
      main_cs = 1'b1; main_addr = 18'h00101;
      exp_addr_q.push_back(22'h000080);
      exp_data_q.push_back(8'hBE);
      wait_req(got, lat);
      total++; if (!got || lat != 1) $display("FAIL main_req_latency got=%0d exp=1", lat); else passed++;
      ea = exp_addr_q.pop_front();
      total++; if (sdram_addr !== ea) $display("FAIL main_sdram_addr got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 2, 16'hBEEF);
      ed = exp_data_q.pop_front();
      total++; if (main_ok !== 1'b1) $display("FAIL main_fill_ok got=%0b exp=1", main_ok); else passed++;
      total++; if (main_data !== ed) $display("FAIL main_fill_data got=%h exp=%h", main_data, ed); else passed++;
      main_addr = 18'h00100;
      #1;
      total++; if (main_ok !== 1'b1 || main_data !== 8'hEF)
         $display("FAIL main_hit_low ok=%0b data=%h exp ok=1 data=ef", main_ok, main_data); else passed++;
      tick(); tick();
      total++; if (sdram_req !== 1'b0) $display("FAIL main_hit_noreq got=%0b exp=0", sdram_req); else passed++;
      main_cs = 1'b0;
   endtask

   task automatic test_snd_mapping();
      snd_cs = 1'b1; snd_addr = 15'h7FFE;
      exp_addr_q.push_back(22'h013FFF);
      exp_data_q.push_back(8'h34);
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL snd_sdram_addr got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(1, 1, 16'h1234);
      ed = exp_data_q.pop_front();
      total++; if (snd_ok !== 1'b1 || snd_data !== ed)
         $display("FAIL snd_fill ok=%0b data=%h exp ok=1 data=%h", snd_ok, snd_data, ed); else passed++;
      snd_addr = 15'h7FFF;
      #1;
      total++; if (snd_ok !== 1'b1 || snd_data !== 8'h12)
         $display("FAIL snd_hit_high ok=%0b data=%h exp ok=1 data=12", snd_ok, snd_data); else passed++;
      snd_cs = 1'b0;
      s2_cs = 1'b1; s2_addr = 15'h0002;
      tick();
      total++; if (req2 !== 1'b1 || addr2 !== 22'h000000)
         $display("FAIL snd_wrap req=%0b addr=%h exp req=1 addr=000000", req2, addr2); else passed++;
      ack2 = 1'b1; dst2 = 1'b1; din2 = 16'h5A3C;
      tick();
      ack2 = 1'b0; dst2 = 1'b0;
      total++; if (s2_ok !== 1'b1 || s2_data !== 8'h3C)
         $display("FAIL snd_wrap_fill ok=%0b data=%h exp ok=1 data=3c", s2_ok, s2_data); else passed++;
      s2_cs = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      main_cs = 1'b1; main_addr = 18'h00200;
      snd_cs  = 1'b1; snd_addr  = 15'h0040;
      exp_addr_q.push_back(22'h000100);
      exp_addr_q.push_back(22'h010020);
      exp_addr_q.push_back(22'h000180);
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL rr_first got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 1, 16'h1111);
      total++; if (main_ok !== 1'b1) $display("FAIL rr_main_fill got=%0b exp=1", main_ok); else passed++;
      // both miss again; main was served last so sound wins
      main_addr = 18'h00300;
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || lat != 1) $display("FAIL rr_second_latency got=%0d exp=1", lat); else passed++;
      total++; if (sdram_addr !== ea) $display("FAIL rr_second got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 1, 16'h2222);
      total++; if (snd_ok !== 1'b1 || snd_data !== 8'h22)
         $display("FAIL rr_snd_fill ok=%0b data=%h exp ok=1 data=22", snd_ok, snd_data); else passed++;
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL rr_third got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 1, 16'h3333);
      total++; if (main_ok !== 1'b1 || main_data !== 8'h33)
         $display("FAIL rr_main_fill2 ok=%0b data=%h exp ok=1 data=33", main_ok, main_data); else passed++;
      // sound fetch while main keeps hitting
      snd_addr = 15'h0080;
      exp_addr_q.push_back(22'h010040);
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL rr_snd_addr got=%h exp=%h", sdram_addr, ea); else passed++;
      total++; if (main_ok !== 1'b1) $display("FAIL rr_hit_during_req got=%0b exp=1", main_ok); else passed++;
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      total++; if (main_ok !== 1'b1 || sdram_req !== 1'b0)
         $display("FAIL rr_hit_during_wait ok=%0b req=%0b exp ok=1 req=0", main_ok, sdram_req); else passed++;
      sdram_dst = 1'b1; sdram_din = 16'h4444;
      tick();
      sdram_dst = 1'b0;
      total++; if (snd_ok !== 1'b1) $display("FAIL rr_snd_fill2 got=%0b exp=1", snd_ok); else passed++;
      main_cs = 1'b0; snd_cs = 1'b0;
   endtask

   task automatic test_addr_change();
      main_cs = 1'b1; main_addr = 18'h00010;
      exp_addr_q.push_back(22'h000008);
      exp_addr_q.push_back(22'h000010);
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL chg_first got=%h exp=%h", sdram_addr, ea); else passed++;
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      main_addr = 18'h00020;
      sdram_dst = 1'b1; sdram_din = 16'h7777;
      tick();
      sdram_dst = 1'b0;
      total++; if (main_ok !== 1'b0) $display("FAIL chg_stale_ok got=%0b exp=0", main_ok); else passed++;
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL chg_refetch got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 1, 16'h8899);
      total++; if (main_ok !== 1'b1 || main_data !== 8'h99)
         $display("FAIL chg_fill ok=%0b data=%h exp ok=1 data=99", main_ok, main_data); else passed++;
      main_cs = 1'b0;
   endtask

   task automatic test_back_to_back();
      main_cs = 1'b1; main_addr = 18'h00401;
      exp_addr_q.push_back(22'h000200);
      exp_data_q.push_back(8'hCD);
      wait_req(got, lat);
      ea = exp_addr_q.pop_front();
      total++; if (!got || sdram_addr !== ea) $display("FAIL b2b_addr got=%h exp=%h", sdram_addr, ea); else passed++;
      respond(0, 0, 16'hCDAB);
      ed = exp_data_q.pop_front();
      total++; if (main_ok !== 1'b1 || main_data !== ed || sdram_req !== 1'b0)
         $display("FAIL b2b_fill ok=%0b data=%h req=%0b exp ok=1 data=%h req=0", main_ok, main_data, sdram_req, ed); else passed++;
      main_cs = 1'b0;
      sdram_dst = 1'b1; sdram_din = 16'h0000;
      tick();
      sdram_dst = 1'b0;
      main_cs = 1'b1; snd_cs = 1'b1; snd_addr = 15'h0080;
      #1;
      total++; if (main_ok !== 1'b1 || main_data !== 8'hCD)
         $display("FAIL idle_dst_main ok=%0b data=%h exp ok=1 data=cd", main_ok, main_data); else passed++;
      total++; if (snd_ok !== 1'b1 || snd_data !== 8'h44)
         $display("FAIL idle_dst_snd ok=%0b data=%h exp ok=1 data=44", snd_ok, snd_data); else passed++;
      tick();
      total++; if (sdram_req !== 1'b0) $display("FAIL idle_dst_req got=%0b exp=0", sdram_req); else passed++;
      main_cs = 1'b0; snd_cs = 1'b0;
   endtask

   initial begin
      test_reset();
      test_main_miss_hit();
      test_snd_mapping();
      test_round_robin();
      test_addr_change();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
